// File: rtl/run_length_serializer.sv
// Run-length serializer: each accepted length becomes that many 1s on bit_o, followed by
// GAP_LEN 0s. This stream is the serial input for the run-length receiver.
module run_length_serializer #(
  parameter int unsigned LEN_W   = 3,
  parameter int unsigned GAP_LEN = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             ready_o,
  output logic             bit_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] runs_o
);

  localparam int unsigned GAP_W = 4;
  localparam logic [GAP_W-1:0] GapLast = GAP_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {StIdle, StMark, StSpace} state_e;

  state_e             r_state, w_state_next;
  logic [LEN_W-1:0]   r_mark_cnt, w_mark_cnt_next;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_next;
  logic               r_bit, r_busy;
  logic [CNT_W-1:0]   r_runs;
  logic               w_last_gap, w_xfer;

  assign w_last_gap = (r_state == StSpace) && (r_gap_cnt == GapLast);
  // The last gap cycle also accepts, so back-to-back runs keep exactly GAP_LEN zeros between them.
  assign ready_o    = !reset_i && ((r_state == StIdle) || w_last_gap);
  assign w_xfer     = valid_i && ready_o;
  assign done_o     = w_last_gap && !reset_i;
  assign bit_o      = r_bit;
  assign busy_o     = r_busy;
  assign runs_o     = r_runs;

  always_comb begin
    w_state_next    = r_state;
    w_mark_cnt_next = r_mark_cnt;
    w_gap_cnt_next  = r_gap_cnt;
    if (w_xfer) begin
      // A zero-length run skips MARK and still produces its gap.
      if (len_i != '0) begin
        w_state_next    = StMark;
        w_mark_cnt_next = len_i;
      end else begin
        w_state_next   = StSpace;
        w_gap_cnt_next = '0;
      end
    end else begin
      unique case (r_state)
        StIdle: ;
        StMark: begin
          if (r_mark_cnt == LEN_W'(1)) begin
            w_state_next   = StSpace;
            w_gap_cnt_next = '0;
          end else begin
            w_mark_cnt_next = r_mark_cnt - LEN_W'(1);
          end
        end
        StSpace: begin
          if (w_last_gap) begin
            w_state_next = StIdle;
          end else begin
            w_gap_cnt_next = r_gap_cnt + GAP_W'(1);
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= StIdle;
      r_mark_cnt <= '0;
      r_gap_cnt  <= '0;
      r_bit      <= 1'b0;
      r_busy     <= 1'b0;
      r_runs     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_mark_cnt <= w_mark_cnt_next;
      r_gap_cnt  <= w_gap_cnt_next;
      r_bit      <= (w_state_next == StMark);
      r_busy     <= (w_state_next != StIdle);
      if (w_last_gap) begin
        r_runs <= r_runs + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_run_length_serializer.sv
// Scoreboard bench for run_length_serializer: the driver queues the expected per-cycle
// bit/done/runs sequence for each accepted length, and a negedge monitor drains and compares it.
module tb_run_length_serializer;

  localparam int unsigned GAP = 2;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       valid_i;
  logic [2:0] len_i;
  logic       ready_o, bit_o, busy_o, done_o;
  logic [7:0] runs_o;

  run_length_serializer #(.LEN_W(3), .GAP_LEN(GAP), .CNT_W(8)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .len_i   (len_i),
    .ready_o (ready_o),
    .bit_o   (bit_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .runs_o  (runs_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       b;
    logic       d;
    logic [7:0] runs;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_runs = 8'd0;
  logic       mon_en   = 1'b0;
  int         nchecks  = 0;
  int         nerrors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    nchecks++;
    nerrors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: any busy cycle must match the next queued entry; an idle cycle must be quiet.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (reset_i) begin
        chk("rst_ready", ready_o, 0);
        chk("rst_done", done_o, 0);
      end else if (busy_o) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_busy");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("bit", bit_o, e.b);
          chk("done", done_o, e.d);
          chk("busy_ready", ready_o, e.d);
          chk("busy_runs", runs_o, e.runs);
        end
      end else begin
        chk("idle_bit", bit_o, 0);
        chk("idle_done", done_o, 0);
        chk("idle_ready", ready_o, 1);
        chk("idle_runs", runs_o, exp_runs);
        if (sb.size() != 0) fail_now("early_idle");
      end
    end
  end

  task automatic send(input logic [2:0] len);
    int n;
    valid_i = 1'b1;
    len_i   = len;
    n = 0;
    @(negedge clk_i);
    while (!ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) begin
      fail_now("ready_timeout");
    end else begin
      @(posedge clk_i);
      for (int i = 0; i < int'(len); i++) sb.push_back('{b: 1'b1, d: 1'b0, runs: exp_runs});
      for (int i = 0; i < int'(GAP); i++)
        sb.push_back('{b: 1'b0, d: (i == int'(GAP) - 1), runs: exp_runs});
      exp_runs = exp_runs + 8'd1;
    end
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk_i);
    while ((busy_o || sb.size() != 0) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (busy_o || sb.size() != 0) fail_now("idle_timeout");
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    len_i   = 3'd0;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    chk("reset_bit", bit_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_runs", runs_o, 0);
    mon_en = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;

    send(3'd4);
    valid_i = 1'b0;
    wait_idle();
    chk("runs_after_4", runs_o, 1);

    // valid_i stays high across both runs
    send(3'd3);
    send(3'd7);
    valid_i = 1'b0;
    wait_idle();
    chk("runs_after_3_7", runs_o, 3);

    send(3'd0);
    valid_i = 1'b0;
    wait_idle();
    chk("runs_after_0", runs_o, 4);

    // Abort a length-6 run in its third mark cycle; the held valid_i must be ignored.
    send(3'd6);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("mark3_bit", bit_o, 1);
    reset_i = 1'b1;
    valid_i = 1'b1;
    len_i   = 3'd5;
    sb.delete();
    exp_runs = 8'd0;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    valid_i = 1'b0;
    chk("abort_bit", bit_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_runs", runs_o, 0);
    chk("abort_done", done_o, 0);
    repeat (2) @(posedge clk_i);
    #1;

    for (int r = 0; r < 256; r++) send(3'd1);
    valid_i = 1'b0;
    wait_idle();
    chk("runs_wrap", runs_o, 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
